debug_host_link: RTL and testbench

- Host-side counterpart of the pipeline debug unit's UART byte protocol.
- Sits on a companion FPGA or in a bench harness, between an external UART Tx/Rx pair and a user or bench controller.
- Issues LOAD, STEP and CONTINUE commands, streams program words out, and collects the pipeline dump bytes into an internal readable buffer.

---
 rtl/debug_host_link.sv | 143 ++++++++++++++
 tb/tb_debug_host_link.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_host_link.sv
// debug_host_link: host-side UART driver issuing LOAD/STEP/CONTINUE and capturing dumps; define DEBUG_HOST_TIMEOUT_EN for an Rx watchdog.
module debug_host_link #(
  parameter int          PROG_DEPTH     = 64,
  parameter int          DUMP_BYTES     = 320,
  parameter logic [7:0]  CMD_LOAD       = 8'h01,
  parameter logic [7:0]  CMD_CONT       = 8'h02,
  parameter logic [7:0]  CMD_STEP       = 8'h03,
  parameter logic [7:0]  ACK_BYTE       = 8'hAA,
  parameter int          TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_prog_we,
  input  logic [5:0]  i_prog_addr,
  input  logic [31:0] i_prog_data,
  input  logic [6:0]  i_prog_count,
  input  logic        is_load,
  input  logic        is_step,
  input  logic        is_cont,
  output logic [7:0]  o_tx_data,
  output logic        os_tx_start,
  input  logic        is_tx_done,
  input  logic [7:0]  i_rx_data,
  input  logic        is_rx_done,
  input  logic [8:0]  i_dump_addr,
  output logic [7:0]  o_dump_data,
  output logic        o_busy,
  output logic        os_done,
  output logic        o_error,
  output logic [8:0]  o_rx_count
);
  typedef enum logic [2:0] {IDLE, TX_CMD, TX_WAIT, TX_CNT, TX_WORD, RX_ACK, RX_DUMP, FINISH} state_t;
  if (PROG_DEPTH < 1 || PROG_DEPTH > 64 || DUMP_BYTES < 1 || DUMP_BYTES > 511 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("debug_host_link: unsupported parameter set");
  end
  state_t      state_q, state_d;
  logic [31:0] prog_mem [PROG_DEPTH];
  logic [7:0]  dump_mem [DUMP_BYTES];
  logic [7:0]  cmd_q, cmd_d, tx_data_q, tx_data_d, dump_data_q;
  logic [6:0]  count_q, count_d;
  logic [8:0]  tx_cnt_q, tx_cnt_d, rx_count_q, rx_count_d, total;
  logic        error_q, error_d, dump_we, start, bad_load, timeout;
  logic [7:0]  start_cmd, word_idx, word_byte;
  logic [31:0] word;
  assign start     = is_load | is_step | is_cont;
  assign start_cmd = is_load ? CMD_LOAD : is_step ? CMD_STEP : CMD_CONT;
  assign bad_load  = is_load && (i_prog_count == 7'd0 || 32'(i_prog_count) > PROG_DEPTH);
  // tx_cnt_q counts bytes already started: cmd, count, then 4 bytes per word
  assign total     = {count_q, 2'b00} + 9'd2;
  assign word_idx  = 8'(tx_cnt_q - 9'd2);
  assign word      = prog_mem[word_idx[7:2]];
  assign word_byte = 8'(word >> {~word_idx[1:0], 3'b000});
  assign o_tx_data   = tx_data_q;
  assign os_tx_start = state_q == TX_CMD || state_q == TX_CNT || state_q == TX_WORD;
  assign o_busy      = state_q != IDLE && state_q != FINISH;
  assign os_done     = state_q == FINISH;
  assign o_error     = error_q;
  assign o_rx_count  = rx_count_q;
  assign o_dump_data = dump_data_q;
`ifdef DEBUG_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q;
  assign timeout = to_q == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    to_q <= (rst || is_rx_done || !(state_q == RX_ACK || state_q == RX_DUMP)) ? '0 : to_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    count_d    = count_q;
    tx_cnt_d   = tx_cnt_q;
    tx_data_d  = tx_data_q;
    rx_count_d = rx_count_q;
    error_d    = error_q;
    dump_we    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        cmd_d      = start_cmd;
        count_d    = i_prog_count;
        tx_cnt_d   = 9'd1;
        tx_data_d  = bad_load ? tx_data_q : start_cmd;
        rx_count_d = '0;
        error_d    = bad_load;
        state_d    = bad_load ? FINISH : TX_CMD;
      end
      TX_CMD, TX_CNT, TX_WORD: state_d = TX_WAIT;
      TX_WAIT: if (is_tx_done) begin
        if (cmd_q != CMD_LOAD) state_d = RX_DUMP;
        else if (tx_cnt_q == total) state_d = RX_ACK;
        else begin
          state_d   = tx_cnt_q == 9'd1 ? TX_CNT : TX_WORD;
          tx_data_d = tx_cnt_q == 9'd1 ? {1'b0, count_q} : word_byte;
          tx_cnt_d  = tx_cnt_q + 9'd1;
        end
      end
      RX_ACK: if (is_rx_done) begin
        error_d = i_rx_data != ACK_BYTE;
        state_d = FINISH;
      end
      RX_DUMP: if (is_rx_done) begin
        dump_we    = 1'b1;
        rx_count_d = rx_count_q + 9'd1;
        state_d    = rx_count_q == 9'(DUMP_BYTES - 1) ? FINISH : RX_DUMP;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout && !is_rx_done && (state_q == RX_ACK || state_q == RX_DUMP)) begin
      error_d = 1'b1;
      state_d = FINISH;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      count_q     <= '0;
      tx_cnt_q    <= '0;
      tx_data_q   <= '0;
      rx_count_q  <= '0;
      error_q     <= 1'b0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      count_q     <= count_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_data_q   <= tx_data_d;
      rx_count_q  <= rx_count_d;
      error_q     <= error_d;
      // a write to the address being read is forwarded so readers see the new byte
      dump_data_q <= (dump_we && rx_count_q == i_dump_addr) ? i_rx_data :
                     i_dump_addr < 9'(DUMP_BYTES) ? dump_mem[i_dump_addr] : 8'h00;
    end
  end
  always_ff @(posedge clk) begin
    if (i_prog_we && !o_busy) prog_mem[i_prog_addr] <= i_prog_data;
    if (dump_we) dump_mem[rx_count_q] <= i_rx_data;
  end
endmodule

// File: tb/tb_debug_host_link.sv
// tb_debug_host_link: randomized self-checking bench with a Tx responder and a byte-level protocol model.
module tb_debug_host_link;
  logic        clk = 0, rst = 1;
  logic        i_prog_we = 0;
  logic [5:0]  i_prog_addr = 0;
  logic [31:0] i_prog_data = 0;
  logic [6:0]  i_prog_count = 0;
  logic        is_load = 0, is_step = 0, is_cont = 0;
  logic [7:0]  o_tx_data;
  logic        os_tx_start;
  logic        is_tx_done = 0;
  logic [7:0]  i_rx_data = 0;
  logic        is_rx_done = 0;
  logic [8:0]  i_dump_addr = 0;
  logic [7:0]  o_dump_data;
  logic        o_busy, os_done, o_error;
  logic [8:0]  o_rx_count;
  int checks = 0, fails = 0;
  int tx_wait = 0, cyc = 0, done_cyc = -1;
  logic [31:0] pm [64];
  logic [7:0]  dm [320];
  logic [7:0]  tx_q [$];
  logic [7:0]  exp_q [$];

  debug_host_link dut (
    .clk(clk), .rst(rst), .i_prog_we(i_prog_we), .i_prog_addr(i_prog_addr),
    .i_prog_data(i_prog_data), .i_prog_count(i_prog_count), .is_load(is_load),
    .is_step(is_step), .is_cont(is_cont), .o_tx_data(o_tx_data), .os_tx_start(os_tx_start),
    .is_tx_done(is_tx_done), .i_rx_data(i_rx_data), .is_rx_done(is_rx_done),
    .i_dump_addr(i_dump_addr), .o_dump_data(o_dump_data), .o_busy(o_busy),
    .os_done(os_done), .o_error(o_error), .o_rx_count(o_rx_count)
  );

  always #5 clk = ~clk;

  // UART Tx stand-in: captures each started byte and answers with a done pulse after a random delay
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      is_tx_done = 0;
      if (rst) tx_wait = 0;
      else if (os_tx_start === 1'b1) begin
        checks++;
        if (tx_wait != 0) begin fails++; $display("FAIL tx_overlap: start while byte pending (%0d cycles left)", tx_wait); end
        if (done_cyc >= 0) begin
          checks++;
          if (cyc != done_cyc + 1) begin fails++; $display("FAIL tx_gap: start at cycle %0d, expected %0d", cyc, done_cyc + 1); end
        end
        tx_q.push_back(o_tx_data);
        tx_wait = $urandom_range(1, 4);
      end else if (tx_wait > 0) begin
        tx_wait--;
        if (tx_wait == 0) begin is_tx_done = 1; done_cyc = cyc; end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void build_load(input int n);
    exp_q = {8'h01, 8'(n)};
    for (int w = 0; w < n; w++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(8'(pm[w] >> (8 * b)));
  endfunction

  task automatic new_txn();
    tx_q.delete();
    done_cyc = -1;
  endtask

  task automatic pulse_start(input bit l, input bit s, input bit c);
    is_load = l; is_step = s; is_cont = c;
    @(negedge clk);
    is_load = 0; is_step = 0; is_cont = 0;
  endtask

  task automatic write_prog(input int a, input logic [31:0] d);
    i_prog_we = 1; i_prog_addr = 6'(a); i_prog_data = d;
    @(negedge clk);
    i_prog_we = 0;
    pm[a] = d;
  endtask

  task automatic send_rx(input logic [7:0] b);
    i_rx_data = b; is_rx_done = 1;
    @(negedge clk);
    is_rx_done = 0;
  endtask

  task automatic check_tx(input string name);
    checks++;
    if (tx_q.size() != exp_q.size()) begin
      fails++; $display("FAIL %s_len: got %0d tx bytes, expected %0d", name, tx_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (tx_q[i] !== exp_q[i]) begin fails++; $display("FAIL %s_byte%0d: got %h, expected %h", name, i, tx_q[i], exp_q[i]); end
    end
  endtask

  task automatic wait_tx(input string name);
    int n = 0;
    while ((tx_q.size() < exp_q.size() || tx_wait != 0) && n < 5000) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    check_tx(name);
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (os_done !== 1'b1 && n < limit) begin @(negedge clk); n++; end
    checks++;
    if (os_done !== 1'b1) begin fails++; $display("FAIL %s_done: no os_done within %0d cycles", name, limit); end
    else begin
      checks++;
      if (o_busy !== 1'b0) begin fails++; $display("FAIL %s_busy_at_done: busy=%b, expected 0", name, o_busy); end
      @(negedge clk);
      checks++;
      if (os_done !== 1'b0) begin fails++; $display("FAIL %s_done_width: os_done=%b a cycle later, expected 0", name, os_done); end
    end
  endtask

  task automatic read_dump(input string name, input int a, input logic [7:0] e);
    i_dump_addr = 9'(a);
    @(negedge clk);
    checks++;
    if (o_dump_data !== e) begin fails++; $display("FAIL %s: dump[%0d]=%h, expected %h", name, a, o_dump_data, e); end
  endtask

  task automatic do_load(input string name, input int n, input logic [7:0] ack, input bit poke);
    new_txn();
    build_load(n);
    i_prog_count = 7'(n);
    pulse_start(1, 0, 0);
    checks++;
    if (o_busy !== 1'b1 || o_error !== 1'b0) begin
      fails++; $display("FAIL %s_start: busy=%b error=%b, expected 1 0", name, o_busy, o_error);
    end
    if (poke) begin
      i_prog_we = 1; i_prog_addr = 6'(n - 1); i_prog_data = ~pm[n - 1];
      @(negedge clk);
      i_prog_we = 0;
    end
    wait_tx(name);
    send_rx(ack);
    wait_done(name, 20);
    checks++;
    if (o_error !== (ack != 8'hAA)) begin fails++; $display("FAIL %s_error: got %b, expected %b", name, o_error, ack != 8'hAA); end
  endtask

  task automatic feed_dump(input string name, input bit rnd);
    for (int i = 0; i < 320; i++) begin
      logic [7:0] b;
      b = rnd ? 8'($urandom) : 8'(i);
      if (rnd && i == 5) begin b = 8'hC3; i_dump_addr = 9'd5; end
      dm[i] = b;
      send_rx(b);
      if (rnd && i == 5) begin
        checks++;
        if (o_dump_data !== 8'hC3) begin fails++; $display("FAIL %s_bypass: dump read %h, expected c3", name, o_dump_data); end
      end
      if (i == 99) begin
        checks++;
        if (o_rx_count !== 9'd100 || o_busy !== 1'b1) begin
          fails++; $display("FAIL %s_mid: rx_count=%0d busy=%b, expected 100 1", name, o_rx_count, o_busy);
        end
      end
      if (i != 319) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_tx_data, os_tx_start, o_busy, os_done, o_error, o_rx_count, o_dump_data} !== '0) begin
      fails++; $display("FAIL reset: tx=%h start=%b busy=%b done=%b err=%b rxc=%0d dump=%h, expected all 0",
                        o_tx_data, os_tx_start, o_busy, os_done, o_error, o_rx_count, o_dump_data);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_load();
    write_prog(0, 32'h20010005);
    write_prog(1, 32'hFC000000);
    do_load("load", 2, 8'hAA, 0);
    do_load("load_nak", 2, 8'h55, 0);
  endtask

  task automatic test_load_random();
    for (int a = 0; a < 64; a++) write_prog(a, $urandom);
    do_load("load_full", 64, 8'hAA, 1);
    for (int k = 0; k < 2; k++) do_load("load_rand", $urandom_range(1, 63), 8'hAA, 1);
    do_load("load_one", 1, 8'hAA, 1);
  endtask

  task automatic test_bad_count();
    int bad [2] = '{0, 65};
    foreach (bad[k]) begin
      new_txn();
      i_prog_count = 7'(bad[k]);
      pulse_start(1, 0, 0);
      wait_done("bad_count", 5);
      checks++;
      if (o_error !== 1'b1) begin fails++; $display("FAIL bad_count_error: count=%0d error=%b, expected 1", bad[k], o_error); end
      repeat (4) @(negedge clk);
      checks++;
      if (tx_q.size() != 0) begin fails++; $display("FAIL bad_count_tx: %0d bytes sent, expected 0", tx_q.size()); end
    end
  endtask

  task automatic test_step();
    new_txn();
    exp_q = {8'h03};
    pulse_start(0, 1, 0);
    checks++;
    if (o_error !== 1'b0 || o_busy !== 1'b1) begin fails++; $display("FAIL step_start: error=%b busy=%b, expected 0 1", o_error, o_busy); end
    wait_tx("step");
    feed_dump("step", 0);
    wait_done("step", 5);
    checks++;
    if (o_rx_count !== 9'd320 || o_error !== 1'b0) begin
      fails++; $display("FAIL step_end: rx_count=%0d error=%b, expected 320 0", o_rx_count, o_error);
    end
    read_dump("step_read257", 257, 8'h01);
    send_rx(8'hEE);
    @(negedge clk);
    checks++;
    if (o_rx_count !== 9'd320) begin fails++; $display("FAIL step_idle_rx: rx_count=%0d, expected 320", o_rx_count); end
    read_dump("step_idle_read0", 0, 8'h00);
  endtask

  task automatic test_cont();
    new_txn();
    exp_q = {8'h02};
    pulse_start(0, 0, 1);
    wait_tx("cont");
    feed_dump("cont", 1);
    wait_done("cont", 5);
    checks++;
    if (o_rx_count !== 9'd320) begin fails++; $display("FAIL cont_count: rx_count=%0d, expected 320", o_rx_count); end
    read_dump("cont_read319", 319, dm[319]);
    for (int k = 0; k < 4; k++) begin
      int a;
      a = $urandom_range(0, 319);
      read_dump("cont_read", a, dm[a]);
    end
  endtask

  task automatic test_priority();
    new_txn();
    build_load(2);
    i_prog_count = 7'd2;
    pulse_start(1, 1, 1);
    repeat (3) begin
      repeat (2) @(negedge clk);
      pulse_start(0, 1, 1);
    end
    wait_tx("priority");
    send_rx(8'hAA);
    wait_done("priority", 20);
    repeat (4) @(negedge clk);
    check_tx("priority_after");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    new_txn();
    build_load(2);
    i_prog_count = 7'd2;
    pulse_start(1, 0, 0);
    while (tx_q.size() < 3 && n < 100) begin @(negedge clk); n++; end
    rst = 1;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || os_tx_start !== 1'b0 || o_tx_data !== 8'h00 || os_done !== 1'b0) begin
      fails++; $display("FAIL reset_mid: busy=%b start=%b tx=%h done=%b, expected 0 0 00 0", o_busy, os_tx_start, o_tx_data, os_done);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if (tx_q.size() < 3 || tx_q[0] !== exp_q[0] || tx_q[1] !== exp_q[1] || tx_q[2] !== exp_q[2]) begin
      fails++; $display("FAIL reset_mid_prefix: %0d bytes seen before reset, expected first 3 of the load", tx_q.size());
    end
    new_txn();
    exp_q = {8'h02};
    pulse_start(0, 0, 1);
    wait_tx("reset_cont");
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load();
    test_bad_count();
    test_step();
    test_cont();
    test_priority();
    test_load_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
